// File: rtl/cpu_pkg.sv
// Shared CPU-wide types and constants.
// Includes the multiply/divide opcode and state encodings.
package cpu_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned MD_LATENCY = 33;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } muldiv_op_t;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_CALC = 2'b01,
        MD_FIN  = 2'b10
    } muldiv_state_t;

endpackage

// File: rtl/muldiv_unit_if.sv
// Control/operand/result bundle between the issue stage and the multiply/divide unit.
interface muldiv_unit_if
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH = XLEN
);
    logic             start;
    muldiv_op_t       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             wr_hi;
    logic             wr_lo;
    logic [WIDTH-1:0] wr_data;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, src_a, src_b, wr_hi, wr_lo, wr_data,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, src_a, src_b, wr_hi, wr_lo, wr_data,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit, one bit per cycle, owning the HI/LO registers.
// Operands are held as magnitudes; signs are reapplied once the iteration finishes.
module muldiv_unit
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH = XLEN,
    parameter int unsigned CNT_W = 5
) (
    input  logic          clk,
    input  logic          rst,
    muldiv_unit_if.slave  bus
);

    localparam int unsigned DW = 2 * WIDTH;

    // Conditional two's-complement negate; 0x80000000 maps to itself
    function automatic logic [WIDTH-1:0] sign_mag(input logic [WIDTH-1:0] x, input logic neg);
        return neg ? (~x + WIDTH'(1)) : x;
    endfunction

    muldiv_state_t    state_q, state_d;
    muldiv_op_t       op_q, op_d;
    logic             neg_q, neg_d;
    logic             a_neg_q, a_neg_d;
    logic             dz_q, dz_d;
    logic [DW-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] bmag_q, bmag_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;

    logic             signed_in, div_in, a_neg_in, b_neg_in, is_div_q, div_ge;
    logic [WIDTH-1:0] a_mag_in, b_mag_in;
    logic [WIDTH:0]   mul_sum, div_shift;
    logic [DW-1:0]    prod_neg;

    // Operand decode at the start edge
    always_comb begin
        signed_in = (bus.op == MD_MULT) || (bus.op == MD_DIV);
        div_in    = (bus.op == MD_DIV)  || (bus.op == MD_DIVU);
        a_neg_in  = signed_in & bus.src_a[WIDTH-1];
        b_neg_in  = signed_in & bus.src_b[WIDTH-1];
        a_mag_in  = sign_mag(bus.src_a, a_neg_in);
        b_mag_in  = sign_mag(bus.src_b, b_neg_in);
    end

    // Per-iteration datapath: shift-add multiply and restoring divide
    always_comb begin
        is_div_q  = (op_q == MD_DIV) || (op_q == MD_DIVU);
        mul_sum   = {1'b0, acc_q[DW-1:WIDTH]} + (acc_q[0] ? {1'b0, bmag_q} : '0);
        div_shift = {rem_q, acc_q[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, bmag_q});
        prod_neg  = ~acc_q + DW'(1);
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        neg_d   = neg_q;
        a_neg_d = a_neg_q;
        dz_d    = dz_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        bmag_d  = bmag_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dbz_d   = dbz_q;

        case (state_q)
            MD_IDLE: begin
                if (bus.start) begin
                    op_d    = bus.op;
                    neg_d   = a_neg_in ^ b_neg_in;
                    a_neg_d = a_neg_in;
                    dz_d    = (bus.src_b == '0);
                    // Low half holds the multiplier (mul) or dividend/quotient (div)
                    acc_d   = {WIDTH'(0), div_in ? a_mag_in : b_mag_in};
                    bmag_d  = div_in ? b_mag_in : a_mag_in;
                    rem_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    dbz_d   = 1'b0;
                    state_d = MD_CALC;
                end else begin
                    if (bus.wr_hi) hi_d = bus.wr_data;
                    if (bus.wr_lo) lo_d = bus.wr_data;
                end
            end
            MD_CALC: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (is_div_q) begin
                    acc_d = {acc_q[DW-1:WIDTH], acc_q[WIDTH-2:0], div_ge};
                    rem_d = div_ge ? WIDTH'(div_shift - {1'b0, bmag_q}) : div_shift[WIDTH-1:0];
                end else begin
                    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                end
                if (cnt_q == CNT_W'(WIDTH - 1)) state_d = MD_FIN;
            end
            MD_FIN: begin
                if (is_div_q) begin
                    // Divide by zero leaves rem = |dividend|, so hi restores the original operand
                    lo_d = dz_q ? '1 : sign_mag(acc_q[WIDTH-1:0], neg_q);
                    hi_d = sign_mag(rem_q, a_neg_q);
                end else begin
                    {hi_d, lo_d} = neg_q ? prod_neg : acc_q;
                end
                dbz_d   = is_div_q & dz_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = MD_IDLE;
            end
            default: state_d = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= MD_IDLE;
            op_q    <= MD_MULT;
            neg_q   <= 1'b0;
            a_neg_q <= 1'b0;
            dz_q    <= 1'b0;
            acc_q   <= '0;
            rem_q   <= '0;
            bmag_q  <= '0;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
            a_neg_q <= a_neg_d;
            dz_q    <= dz_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            bmag_q  <= bmag_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes expected HI/LO/div_by_zero,
// a monitor pops and compares on every done pulse.
module tb_muldiv_unit;
    import cpu_pkg::*;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   done_seen = 0;
    exp_t sb[$];

    muldiv_unit_if #(.WIDTH(32)) mif ();

    muldiv_unit #(.WIDTH(32), .CNT_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (mif.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!rst && mif.done) begin
            done_seen++;
            if (sb.size() == 0) begin
                check("unexpected_done", 64'(mif.done), 64'(0));
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_hi"},   64'(mif.hi),          64'(e.hi));
                check({e.name, "_lo"},   64'(mif.lo),          64'(e.lo));
                check({e.name, "_dbz"},  64'(mif.div_by_zero), 64'(e.dbz));
                check({e.name, "_busy_at_done"}, 64'(mif.busy), 64'(0));
            end
        end
    end

    // Called at a negedge; returns at the negedge where done is seen
    task automatic run_op(input string name, input muldiv_op_t op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input logic exp_dbz, input bit disturb);
        logic [31:0] hi0, lo0;
        int busy_cyc, waited;
        bit stable;
        hi0 = mif.hi;
        lo0 = mif.lo;
        mif.start = 1'b1;
        mif.op    = op;
        mif.src_a = a;
        mif.src_b = b;
        if (disturb) begin
            mif.wr_hi   = 1'b1;
            mif.wr_data = 32'hDEAD_BEEF;
        end
        sb.push_back('{name, exp_hi, exp_lo, exp_dbz});
        @(negedge clk);
        mif.start = 1'b0;
        mif.wr_hi = 1'b0;
        mif.src_a = 32'h0BAD_0BAD;
        mif.src_b = 32'h0000_0001;
        mif.op    = MD_MULT;
        check({name, "_busy_after_start"}, 64'(mif.busy), 64'(1));
        check({name, "_dbz_cleared"},      64'(mif.div_by_zero), 64'(0));
        busy_cyc = 1;
        waited   = 0;
        stable   = 1'b1;
        while (!mif.done && waited < 40) begin
            if (mif.hi !== hi0 || mif.lo !== lo0) stable = 1'b0;
            if (disturb && waited == 5) begin
                mif.start   = 1'b1;
                mif.wr_hi   = 1'b1;
                mif.wr_lo   = 1'b1;
                mif.wr_data = 32'h5555_AAAA;
                mif.src_a   = 32'hFFFF_FFFF;
            end
            if (disturb && waited == 8) begin
                mif.start = 1'b0;
                mif.wr_hi = 1'b0;
                mif.wr_lo = 1'b0;
            end
            @(negedge clk);
            waited++;
            if (mif.busy) busy_cyc++;
        end
        check({name, "_done_seen"},    64'(mif.done), 64'(1));
        check({name, "_latency"},      64'(waited),   64'(MD_LATENCY));
        check({name, "_busy_cycles"},  64'(busy_cyc), 64'(MD_LATENCY));
        check({name, "_hilo_stable"},  64'(stable),   64'(1));
    endtask

    initial begin
        int done_before;
        mif.start   = 1'b0;
        mif.op      = MD_MULT;
        mif.src_a   = '0;
        mif.src_b   = '0;
        mif.wr_hi   = 1'b0;
        mif.wr_lo   = 1'b0;
        mif.wr_data = '0;

        repeat (2) @(negedge clk);
        check("reset_busy", 64'(mif.busy), 64'(0));
        check("reset_done", 64'(mif.done), 64'(0));
        check("reset_dbz",  64'(mif.div_by_zero), 64'(0));
        check("reset_hilo", {mif.hi, mif.lo}, 64'(0));
        rst = 1'b0;

        // MTHI and MTLO together, then MTLO alone
        @(negedge clk);
        mif.wr_hi = 1'b1; mif.wr_lo = 1'b1; mif.wr_data = 32'h1234_5678;
        @(negedge clk);
        mif.wr_hi = 1'b0; mif.wr_lo = 1'b0;
        check("mt_both", {mif.hi, mif.lo}, {32'h1234_5678, 32'h1234_5678});
        mif.wr_lo = 1'b1; mif.wr_data = 32'h0000_00A5;
        @(negedge clk);
        mif.wr_lo = 1'b0;
        check("mtlo_only", {mif.hi, mif.lo}, {32'h1234_5678, 32'h0000_00A5});

        // Back-to-back: each op starts on the previous op's done cycle
        run_op("mult_neg",    MD_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1'b0);
        run_op("multu_max",   MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b0);
        run_op("mult_minmin", MD_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 1'b0);
        run_op("div_neg",     MD_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0);
        run_op("div_negdiv",  MD_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 1'b0);
        run_op("div_ovf",     MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 1'b0);
        run_op("divu_zero",   MD_DIVU,  32'd5,         32'd0,         32'h0000_0005, 32'hFFFF_FFFF, 1'b1, 1'b0);

        repeat (3) @(negedge clk);
        check("dbz_held_idle", 64'(mif.div_by_zero), 64'(1));

        run_op("multu_small", MD_MULTU, 32'd2,         32'd3,         32'h0000_0000, 32'h0000_0006, 1'b0, 1'b1);
        run_op("div_zero_sg", MD_DIV,   32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1, 1'b0);
        run_op("divu_100_7",  MD_DIVU,  32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E, 1'b0, 1'b1);

        // Asynchronous reset ten cycles into an operation aborts it
        mif.start = 1'b1; mif.op = MD_DIVU; mif.src_a = 32'd100; mif.src_b = 32'd7;
        @(negedge clk);
        mif.start = 1'b0;
        repeat (9) @(negedge clk);
        check("abort_busy_before", 64'(mif.busy), 64'(1));
        done_before = done_seen;
        #2 rst = 1'b1;
        #1;
        check("abort_busy", 64'(mif.busy), 64'(0));
        check("abort_hilo", {mif.hi, mif.lo}, 64'(0));
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("abort_no_done", 64'(done_seen), 64'(done_before));
        check("abort_idle_busy", 64'(mif.busy), 64'(0));
        check("scoreboard_empty", 64'(sb.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
